// File: rtl/hub75_column_loader.sv
// Streams one theta slice from the voxel frame BRAM, one scan-row pair at a time,
// and presents each pair to the HUB75 output stage over a valid/ready handshake.
module hub75_column_loader #(
    parameter int ROTATIONAL_RES = 180,
    parameter int NUM_COLS       = 64,
    parameter int NUM_ROWS       = 64,
    parameter int SCAN_RATE      = 32,
    parameter int THETA_RES      = 8,
    parameter int PIX_W          = 9,
    parameter int READ_LATENCY   = 2,
    parameter int ADDR_W         = $clog2(ROTATIONAL_RES * SCAN_RATE * NUM_COLS)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [THETA_RES-1:0]          theta_in,
    input  logic                          theta_valid,
    output logic [ADDR_W-1:0]             bram_addr,
    output logic                          bram_rd_en,
    input  logic [2*PIX_W-1:0]            bram_data,
    output logic [PIX_W*NUM_COLS-1:0]     column_data0,
    output logic [PIX_W*NUM_COLS-1:0]     column_data1,
    output logic [$clog2(SCAN_RATE)-1:0]  col_index,
    output logic                          tvalid,
    input  logic                          tready,
    output logic                          theta_err
);
    localparam int ROW_W = $clog2(SCAN_RATE);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(NUM_COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(SCAN_RATE - 1);
    localparam logic [ADDR_W-1:0] SLICE_WORDS = ADDR_W'(SCAN_RATE * NUM_COLS);
    localparam logic [ADDR_W-1:0] ROW_WORDS   = ADDR_W'(NUM_COLS);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_t;

    state_t                 state, state_next;
    logic                   pend;
    logic [THETA_RES-1:0]   pend_theta;
    logic [THETA_RES-1:0]   cur_theta;
    logic [ROW_W-1:0]       row;
    logic [COL_W-1:0]       col;
    logic                   pipe_v [READ_LATENCY];
    logic [COL_W-1:0]       pipe_c [READ_LATENCY];

    logic theta_legal, theta_ok, fetch_last, drain_done, handshake;

    assign theta_legal = 32'(theta_in) < ROTATIONAL_RES;
    assign theta_ok    = theta_valid && theta_legal;
    assign fetch_last  = (col == LAST_COL);
    assign drain_done  = pipe_v[READ_LATENCY-1] && (pipe_c[READ_LATENCY-1] == LAST_COL);
    assign handshake   = tvalid && tready;

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        bram_rd_en = 1'b0;
        bram_addr  = '0;
        case (state)
            IDLE:    if (pend) state_next = FETCH;
            FETCH: begin
                bram_rd_en = 1'b1;
                bram_addr  = ADDR_W'(cur_theta) * SLICE_WORDS
                           + ADDR_W'(row) * ROW_WORDS + ADDR_W'(col);
                if (fetch_last) state_next = DRAIN;
            end
            DRAIN:   if (drain_done) state_next = PRESENT;
            PRESENT: if (handshake) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend         <= 1'b0;
            pend_theta   <= '0;
            cur_theta    <= '0;
            row          <= '0;
            col          <= '0;
            tvalid       <= 1'b0;
            col_index    <= '0;
            theta_err    <= 1'b0;
            column_data0 <= '0;
            column_data1 <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_c[i] <= '0;
            end
        end else begin
            theta_err <= theta_valid && !theta_legal;

            if (state == IDLE && pend) begin
                cur_theta <= pend_theta;
                row       <= '0;
                pend      <= 1'b0;
            end
            // A strobe landing in the same cycle as IDLE consumption stays pending.
            if (theta_ok) begin
                pend       <= 1'b1;
                pend_theta <= theta_in;
            end

            if (state == FETCH) col <= fetch_last ? '0 : col + 1'b1;

            if (state == DRAIN && drain_done) begin
                tvalid    <= 1'b1;
                col_index <= row;
            end

            // Row boundary: a strobe arriving with the handshake beats the stored one.
            if (state == PRESENT && handshake) begin
                tvalid <= 1'b0;
                if (theta_ok) begin
                    cur_theta <= theta_in;
                    pend      <= 1'b0;
                    row       <= '0;
                end else if (pend) begin
                    cur_theta <= pend_theta;
                    pend      <= 1'b0;
                    row       <= '0;
                end else if (row == LAST_ROW) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end

            pipe_v[0] <= bram_rd_en;
            pipe_c[0] <= col;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_c[i] <= pipe_c[i-1];
            end

            if (pipe_v[READ_LATENCY-1]) begin
                column_data0[PIX_W*pipe_c[READ_LATENCY-1] +: PIX_W] <= bram_data[PIX_W-1:0];
                column_data1[PIX_W*pipe_c[READ_LATENCY-1] +: PIX_W] <= bram_data[2*PIX_W-1:PIX_W];
            end
        end
    end
endmodule

// File: tb/tb_hub75_column_loader.sv
// Bench for hub75_column_loader: a timing/transaction model predicts reads,
// presentations and theta switching; directed phases pin literal addresses.
module tb_hub75_column_loader;
    localparam int NC = 64;
    localparam int SR = 32;
    localparam int RL = 2;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic [7:0]   theta_in = '0;
    logic         theta_valid = 1'b0;
    logic [18:0]  bram_addr;
    logic         bram_rd_en;
    logic [17:0]  bram_data;
    logic [575:0] column_data0, column_data1;
    logic [4:0]   col_index;
    logic         tvalid;
    logic         tready = 1'b0;
    logic         theta_err;

    int n_tests = 0;
    int n_fail  = 0;

    hub75_column_loader #(
        .ROTATIONAL_RES(180), .NUM_COLS(NC), .NUM_ROWS(64), .SCAN_RATE(SR),
        .THETA_RES(8), .PIX_W(9), .READ_LATENCY(RL)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .theta_in(theta_in), .theta_valid(theta_valid),
        .bram_addr(bram_addr), .bram_rd_en(bram_rd_en), .bram_data(bram_data),
        .column_data0(column_data0), .column_data1(column_data1), .col_index(col_index),
        .tvalid(tvalid), .tready(tready), .theta_err(theta_err)
    );

    initial forever #5 clk_in = ~clk_in;

    // BRAM: two-cycle read latency, word = {addr[8:0]+1, addr[8:0]}
    logic [18:0] a1 = '0, a2 = '0;
    always @(posedge clk_in) begin
        a1 <= bram_addr;
        a2 <= a1;
    end
    assign bram_data = {a2[8:0] + 9'd1, a2[8:0]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [8:0] exp_pix(input int base, input int c, input bit bottom);
        int v;
        v = (base + c) % 512;
        if (bottom) v = (v + 1) % 512;
        return v[8:0];
    endfunction

    task automatic chk_row(input int base);
        int bad;
        bad = -1;
        n_tests++;
        for (int c = NC - 1; c >= 0; c--)
            if (column_data0[9*c +: 9] !== exp_pix(base, c, 0) ||
                column_data1[9*c +: 9] !== exp_pix(base, c, 1)) bad = c;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL row_data: pixel %0d got top %0d bot %0d expected top %0d bot %0d",
                     bad, column_data0[9*bad +: 9], column_data1[9*bad +: 9],
                     exp_pix(base, bad, 0), exp_pix(base, bad, 1));
        end
    endtask

    // Reference model, evaluated at each negedge from the inputs the next posedge will see.
    int cyc = 0;
    bit seen_rst = 0, post_rst = 0, m_active = 0, m_pend = 0, exp_err = 0;
    int m_theta = 0, m_row = 0, m_pend_theta = 0;
    int reads_done = 0, fetch_start = 0, t_first = 0;

    always @(negedge clk_in) begin
        bit exp_rd, exp_tv, hs, legal;
        int base;
        cyc++;
        base   = m_theta * SR * NC + m_row * NC;
        exp_rd = m_active && reads_done < NC && cyc >= fetch_start;
        exp_tv = m_active && reads_done == NC && cyc >= t_first + NC + RL;
        if (seen_rst) begin
            chk("rd_en", bram_rd_en, exp_rd);
            if (exp_rd) chk("addr", bram_addr, base + reads_done);
            chk("tvalid", tvalid, exp_tv);
            chk("theta_err", theta_err, exp_err);
            if (exp_tv) begin
                chk("col_index", col_index, m_row);
                chk_row(base);
            end
            if (!m_active) chk("idle_data_zero", (column_data0 == '0 && column_data1 == '0), 1);
            if (post_rst) begin
                chk("rst_addr", bram_addr, 0);
                chk("rst_col_index", col_index, 0);
            end
        end

        if (exp_rd) begin
            if (reads_done == 0) t_first = cyc;
            reads_done++;
        end
        legal = theta_valid && theta_in < 8'd180;
        hs    = exp_tv && tready;
        if (rst_in) begin
            seen_rst = 1; post_rst = 1; m_active = 0; m_pend = 0; exp_err = 0;
            reads_done = 0; m_row = 0; m_theta = 0;
        end else begin
            post_rst = 0;
            exp_err  = theta_valid && !legal;
            if (hs) begin
                if (legal) begin
                    m_theta = theta_in; m_pend = 0; m_row = 0;
                end else if (m_pend) begin
                    m_theta = m_pend_theta; m_pend = 0; m_row = 0;
                end else begin
                    m_row = (m_row + 1) % SR;
                end
                reads_done  = 0;
                fetch_start = cyc + 1;
            end else if (legal) begin
                if (!m_active) begin
                    m_active = 1; m_theta = theta_in; m_row = 0;
                    reads_done = 0; fetch_start = cyc + 2;
                end else begin
                    m_pend = 1; m_pend_theta = theta_in;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_rd(input string name);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_in);
            if (bram_rd_en) return;
        end
        timeout_fail(name);
    endtask

    task automatic wait_tv(input string name);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_in);
            if (tvalid) return;
        end
        timeout_fail(name);
    endtask

    task automatic strobe(input logic [7:0] t);
        theta_valid = 1'b1;
        theta_in    = t;
        step();
        theta_valid = 1'b0;
    endtask

    initial begin
        int lat;
        repeat (3) step();
        rst_in = 1'b0;
        step();
        strobe(8'd5);

        // First row of theta 5 with the consumer stalled
        wait_rd("first_read");
        chk("first_addr", bram_addr, 10240);
        lat = 0;
        for (int k = 0; k < 200 && !tvalid; k++) begin
            @(negedge clk_in);
            lat++;
        end
        chk("first_latency", lat, 66);
        chk("first_col_index", col_index, 0);
        chk("pix5_top", column_data0[9*5 +: 9], 5);
        chk("pix63_bot", column_data1[9*63 +: 9], 64);
        repeat (50) @(negedge clk_in);
        chk("held_tvalid", tvalid, 1);
        step();
        tready = 1'b1;
        @(negedge clk_in);
        wait_rd("row1_read");
        chk("row1_addr", bram_addr, 10304);

        // Remaining rows, then wrap to row 0 of the same theta
        for (int r = 1; r < SR; r++) begin
            wait_tv("row_tv");
            chk("row_seq", col_index, r);
        end
        wait_rd("wrap_read");
        chk("wrap_addr", bram_addr, 10240);
        wait_tv("wrap_tv");
        chk("wrap_col_index", col_index, 0);

        // Two strobes during the row-3 fetch: the later one wins
        wait_tv("r1_tv");
        wait_tv("r2_tv");
        wait_rd("r3_read");
        step();
        strobe(8'd7);
        strobe(8'd9);
        wait_tv("r3_tv");
        chk("r3_col_index", col_index, 3);
        wait_rd("theta9_read");
        chk("theta9_addr", bram_addr, 18432);
        wait_tv("theta9_tv");
        chk("theta9_col_index", col_index, 0);

        // Out-of-range theta
        step();
        strobe(8'd200);
        @(negedge clk_in);
        chk("err_pulse", theta_err, 1);
        @(negedge clk_in);
        chk("err_single", theta_err, 0);

        // Reset during the first DRAIN cycle, with read data still in flight
        wait_tv("pre_rst_tv");
        wait_rd("pre_rst_read");
        repeat (64) step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_rd_en", bram_rd_en, 0);
        chk("rst_data0_zero", column_data0 == '0, 1);
        repeat (4) @(negedge clk_in);
        chk("late_data_ignored", column_data1 == '0, 1);
        step();
        strobe(8'd11);
        wait_rd("restart_read");
        chk("restart_addr", bram_addr, 22528);
        wait_tv("restart_tv");
        chk("restart_col_index", col_index, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            tready      = ($urandom_range(0, 3) != 0);
            theta_valid = ($urandom_range(0, 59) == 0);
            theta_in    = 8'($urandom_range(0, 199));
            rst_in      = ($urandom_range(0, 1499) == 0);
        end
        step();
        theta_valid = 1'b0;
        rst_in      = 1'b0;
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hub75_column_loader.md
Name: hub75_column_loader

Overview:
- Upstream feeder for the HUB75 output stage.
- For the current rotational angle (theta), it streams the 64x64 slice image out of the voxel frame BRAM one scan-row pair at a time. Scan row r (top half) and row r+SCAN_RATE (bottom half) are sent together with col_index = r over a valid/ready handshake.
- It re-scans the same theta continuously and switches to a new theta only at a row boundary.

Parameters:
- ROTATIONAL_RES, 180: number of theta slices stored in BRAM.
- NUM_COLS, 64: pixels per scan row (shift length of the output stage).
- NUM_ROWS, 64: panel rows.
- SCAN_RATE, 32: scan row pairs per slice (NUM_ROWS/2).
- THETA_RES, 8: width of the theta index.
- PIX_W, 9: bits per pixel (3 bits per colour, RGB).
- READ_LATENCY, 2: BRAM read latency in cycles, from addr to data; must be ≥1.
- ADDR_W, $clog2(ROTATIONAL_RES*SCAN_RATE*NUM_COLS): BRAM address width (19 with defaults).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- theta_in  input  THETA_RES  new slice index from the rotation tracker
- theta_valid  input  1  one-cycle strobe qualifying theta_in
- bram_addr  output  ADDR_W  frame BRAM read address
- bram_rd_en  output  1  read enable
- bram_data  input  2*PIX_W  read word, {bottom pixel[17:9], top pixel[8:0]}
- column_data0  output  PIX_W*NUM_COLS  top-half row; pixel c at bits [PIX_W*c +: PIX_W]
- column_data1  output  PIX_W*NUM_COLS  bottom-half row, same packing
- col_index  output  $clog2(SCAN_RATE)  scan row r of the presented data
- tvalid  output  1  presented data valid
- tready  input  1  consumer ready
- theta_err  output  1  one-cycle pulse when an out-of-range theta is rejected

Behaviour:
- Reset (synchronous, clk_in, rst_in=1) clears the following, and takes priority over everything, including mid-fetch and mid-present:
  - state=IDLE
  - tvalid=0, bram_rd_en=0, bram_addr=0
  - column_data0/1=0, col_index=0, theta_err=0
  - pending theta flag and the read-valid pipeline; in-flight BRAM data arriving after reset is discarded.
- Theta capture:
  - A theta_valid with theta_in<ROTATIONAL_RES stores theta_in in pend_theta and sets pend=1. A later strobe before consumption overwrites it (last wins).
  - theta_in≥ROTATIONAL_RES is ignored and pulses theta_err the next cycle.
- States:
  - IDLE: wait for pend. On pend: cur_theta←pend_theta, pend←0, row←0, go to FETCH.
  - FETCH: issue NUM_COLS reads on consecutive cycles, c=0..NUM_COLS-1, with bram_rd_en=1 and bram_addr=cur_theta*SCAN_RATE*NUM_COLS + row*NUM_COLS + c. Then go to DRAIN.
  - DRAIN: keep capturing data until READ_LATENCY cycles after the last address. When done: tvalid←1, col_index←row, go to PRESENT.
  - PRESENT: hold tvalid and column_data0/1/col_index stable until tvalid&&tready. On that cycle, tvalid←0 and select the next row:
    - if pend=1: cur_theta←pend_theta, pend←0, row←0;
    - else if row==SCAN_RATE-1: row←0 (wraps, same theta);
    - else row←row+1.
    Then go to FETCH on the next cycle.
- Data capture: a READ_LATENCY-deep shift pipeline of {valid, c} tags follows each read. Returned word c writes bram_data[8:0] into pixel c of column_data0 and bram_data[17:9] into pixel c of column_data1.
- column_data may change while tvalid=0. It is never modified while tvalid=1.
- Latency:
  - theta_valid in IDLE → first bram_rd_en: 2 cycles (capture, then state change).
  - First address → tvalid: NUM_COLS+READ_LATENCY cycles.
  - Handshake → next tvalid: 1+NUM_COLS+READ_LATENCY cycles.
- tready while tvalid=0 has no effect. tvalid never drops without a handshake, except on reset.
- A theta_valid on the same cycle as a PRESENT handshake counts as pending for that boundary: the newly strobed theta is used.
- Address arithmetic uses ADDR_W-bit unsigned math with no overflow for legal theta.

Test Plan:
- Reset, theta_in=5 strobe, BRAM model word = {addr[8:0]+1, addr[8:0]}, tready=1 → first address 10240, tvalid rises 66 cycles after the first address, col_index=0, pixel c of column_data0 = (10240+c)[8:0].
- Hold tready=0 for 50 cycles while tvalid=1 → tvalid, col_index and column_data remain stable; no BRAM reads occur; after tready=1, one handshake, then the row-1 fetch starts at address 10304.
- Run theta 5 through 33 handshakes → col_index sequence 0..31 then 0 again; the row-0 address repeats 10240.
- Strobe theta 7, then theta 9, during the row-3 fetch of theta 5 → after the row-3 handshake, the next fetch starts at 9*2048=18432 with col_index 0; theta 7 is never used.
- Strobe theta_in=200 → theta_err pulses once; the state and addresses are unchanged.
- Assert rst_in mid-DRAIN → next cycle all outputs are 0 and the state is IDLE; late BRAM data does not alter column_data; a new theta restarts cleanly.
